// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and defaults for the convolution pass sequencer
package conv_pkg;

    localparam int CONV_ROWS  = 32;
    localparam int CONV_DIM_W = 5;
    localparam int CONV_PIX_W = 10;
    localparam int CONV_CH_W  = 4;

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} seq_state_t;

    typedef enum logic [1:0] {MASK_OFF, MASK_ON, MASK_DRAIN} mask_mode_t;

    typedef struct packed {
        logic [CONV_DIM_W-1:0] weight_dim;
        logic [CONV_PIX_W-1:0] pixel_count;
        logic [CONV_CH_W-1:0]  num_passes;
    } conv_cfg_t;

endpackage

// File: rtl/row_stagger_mask.sv
// rtl/row_stagger_mask.sv - per-row input enable vector with staggered drain shut-off
module row_stagger_mask
    import conv_pkg::*;
#(
    parameter int ROWS = CONV_ROWS,
    localparam int RW  = $clog2(ROWS)
) (
    input  logic [1:0]      mode,
    input  logic [RW-1:0]   d,
    output logic [ROWS-1:0] input_en
);

    always_comb begin
        input_en = '0;
        case (mask_mode_t'(mode))
            MASK_ON:    input_en = '1;
            // Rows 0..d have already seen their last operand and are shut off.
            MASK_DRAIN: for (int i = 0; i < ROWS; i++) input_en[i] = (i > int'(d));
            default:    input_en = '0;
        endcase
    end

endmodule

// File: rtl/conv_pass_sequencer.sv
// rtl/conv_pass_sequencer.sv - multi-pass weight load / stream / drain sequencer for the systolic array
module conv_pass_sequencer
    import conv_pkg::*;
#(
    parameter int ROWS  = CONV_ROWS,
    parameter int DIM_W = CONV_DIM_W,
    parameter int PIX_W = CONV_PIX_W,
    parameter int CH_W  = CONV_CH_W
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] weight_dim,
    input  logic [PIX_W-1:0] pixel_count,
    input  logic [CH_W-1:0]  num_passes,
    output logic             w_ps,
    output logic [ROWS-1:0]  input_en,
    output logic             out_valid,
    output logic             acc_first,
    output logic [CH_W-1:0]  pass_idx,
    output logic             pass_done,
    output logic             conv_finish,
    output logic             busy,
    output logic             cfg_err
);

    localparam int RW = $clog2(ROWS);

    seq_state_t       state;
    conv_cfg_t        cfg;
    conv_cfg_t        req;
    logic [RW-1:0]    row_cnt;
    logic [PIX_W-1:0] pix_cnt;
    logic [DIM_W-1:0] ov_wait;
    logic [PIX_W-1:0] ov_left;
    logic             req_ok;
    mask_mode_t       mask_mode;

    assign req = '{weight_dim: weight_dim, pixel_count: pixel_count, num_passes: num_passes};
    assign req_ok = (pixel_count != '0) && (num_passes != '0) && (weight_dim != '0)
                 && (32'(weight_dim) <= 32'(ROWS));

    assign mask_mode = (state == LOAD_W || state == STREAM) ? MASK_ON :
                       (state == DRAIN) ? MASK_DRAIN : MASK_OFF;

    row_stagger_mask #(.ROWS(ROWS)) u_mask (
        .mode     (mask_mode),
        .d        (row_cnt),
        .input_en (input_en)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE; cfg <= '0; row_cnt <= '0; pix_cnt <= '0; ov_wait <= '0; ov_left <= '0;
            w_ps <= 1'b1; out_valid <= 1'b0; acc_first <= 1'b0; pass_idx <= '0;
            pass_done <= 1'b0; conv_finish <= 1'b0; busy <= 1'b0; cfg_err <= 1'b0;
        end else if (abort) begin
            state <= IDLE; cfg <= '0; row_cnt <= '0; pix_cnt <= '0; ov_wait <= '0; ov_left <= '0;
            w_ps <= 1'b1; out_valid <= 1'b0; acc_first <= 1'b0; pass_idx <= '0;
            pass_done <= 1'b0; conv_finish <= 1'b0; busy <= 1'b0; cfg_err <= 1'b0;
        end else begin
            pass_done   <= 1'b0;
            conv_finish <= 1'b0;
            cfg_err     <= 1'b0;

            // Result window runs off its own counters so it can trail into DRAIN.
            if (ov_wait != '0) begin
                ov_wait <= ov_wait - DIM_W'(1);
                if (ov_wait == DIM_W'(1)) begin
                    out_valid <= 1'b1;
                    acc_first <= (pass_idx == '0);
                    ov_left   <= cfg.pixel_count - PIX_W'(1);
                end
            end else if (out_valid) begin
                if (ov_left == '0) begin
                    out_valid <= 1'b0;
                    acc_first <= 1'b0;
                end else begin
                    ov_left <= ov_left - PIX_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (req_ok) begin
                            cfg     <= req;
                            state   <= LOAD_W;
                            busy    <= 1'b1;
                            row_cnt <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                LOAD_W: begin
                    if (row_cnt == RW'(ROWS - 1)) begin
                        row_cnt <= '0;
                        pix_cnt <= '0;
                        w_ps    <= 1'b0;
                        ov_wait <= cfg.weight_dim;
                        state   <= STREAM;
                    end else begin
                        row_cnt <= row_cnt + RW'(1);
                    end
                end
                STREAM: begin
                    if (pix_cnt == cfg.pixel_count - PIX_W'(1)) begin
                        row_cnt <= '0;
                        state   <= DRAIN;
                    end else begin
                        pix_cnt <= pix_cnt + PIX_W'(1);
                    end
                end
                DRAIN: begin
                    pass_done <= (row_cnt == RW'(ROWS - 2));
                    if (row_cnt == RW'(ROWS - 1)) begin
                        row_cnt <= '0;
                        w_ps    <= 1'b1;
                        if (pass_idx == cfg.num_passes - CH_W'(1)) begin
                            state       <= DONE;
                            conv_finish <= 1'b1;
                        end else begin
                            pass_idx <= pass_idx + CH_W'(1);
                            state    <= LOAD_W;
                        end
                    end else begin
                        row_cnt <= row_cnt + RW'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    pass_idx <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// tb/tb_conv_pass_sequencer.sv - randomized scoreboard bench for conv_pass_sequencer
module tb_conv_pass_sequencer;

    localparam int ROWS = 4;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] weight_dim = '0;
    logic [9:0] pixel_count = '0;
    logic [3:0] num_passes = '0;
    logic            w_ps, out_valid, acc_first, pass_done, conv_finish, busy, cfg_err;
    logic [ROWS-1:0] input_en;
    logic [3:0]      pass_idx;

    conv_pass_sequencer #(.ROWS(ROWS)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .weight_dim(weight_dim), .pixel_count(pixel_count), .num_passes(num_passes),
        .w_ps(w_ps), .input_en(input_en), .out_valid(out_valid), .acc_first(acc_first),
        .pass_idx(pass_idx), .pass_done(pass_done), .conv_finish(conv_finish),
        .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic            busy;
        logic            w_ps;
        logic [ROWS-1:0] en;
        logic            ov;
        logic            af;
        logic [3:0]      pidx;
        logic            pd;
        logic            cf;
        logic            ce;
    } obs_t;

    typedef struct {
        int         c;
        logic       af;
        logic [3:0] pidx;
    } beat_t;

    obs_t  exp_tab[int];
    beat_t beat_q[$];
    int    model_end = 0;
    int    vectors = 0;
    int    miscompares = 0;

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.w_ps = 1'b1;
        return o;
    endfunction

    function automatic obs_t want_at(int c);
        if (exp_tab.exists(c)) return exp_tab[c];
        return idle_obs();
    endfunction

    function automatic obs_t observed();
        obs_t g;
        g = '{busy: busy, w_ps: w_ps, en: input_en, ov: out_valid, af: acc_first,
              pidx: pass_idx, pd: pass_done, cf: conv_finish, ce: cfg_err};
        return g;
    endfunction

    // Expected cycle-by-cycle trace of one run, start sampled in cycle n0.
    task automatic model_run(int n0, int wd, int pc, int np);
        obs_t o;
        int t, s;
        t = n0 + 1;
        if (pc == 0 || np == 0 || wd == 0 || wd > ROWS) begin
            o = idle_obs();
            o.ce = 1'b1;
            exp_tab[t] = o;
            if (t > model_end) model_end = t;
            return;
        end
        for (int p = 0; p < np; p++) begin
            for (int k = 0; k < ROWS; k++) begin
                o = idle_obs(); o.busy = 1'b1; o.en = '1; o.pidx = 4'(p);
                exp_tab[t] = o; t++;
            end
            s = t;
            for (int k = 0; k < pc; k++) begin
                o = idle_obs(); o.busy = 1'b1; o.w_ps = 1'b0; o.en = '1; o.pidx = 4'(p);
                exp_tab[t] = o; t++;
            end
            for (int d = 0; d < ROWS; d++) begin
                o = idle_obs(); o.busy = 1'b1; o.w_ps = 1'b0; o.pidx = 4'(p);
                o.en = ROWS'(((1 << ROWS) - 1) & ~((2 << d) - 1));
                o.pd = (d == ROWS - 1);
                exp_tab[t] = o; t++;
            end
            for (int v = 0; v < pc; v++) begin
                o = exp_tab[s + wd + v];
                o.ov = 1'b1;
                o.af = (p == 0);
                exp_tab[s + wd + v] = o;
                beat_q.push_back('{c: s + wd + v, af: (p == 0), pidx: 4'(p)});
            end
        end
        o = idle_obs(); o.busy = 1'b1; o.cf = 1'b1; o.pidx = 4'(np - 1);
        exp_tab[t] = o;
        model_end = t;
    endtask

    // Anything scheduled after cycle a never happens (abort or reset).
    task automatic cancel_after(int a);
        beat_t keep[$];
        for (int k = a + 1; k <= model_end; k++) exp_tab.delete(k);
        foreach (beat_q[i]) if (beat_q[i].c <= a) keep.push_back(beat_q[i]);
        beat_q = keep;
        if (model_end > a) model_end = a;
    endtask

    task automatic do_start(int wd, int pc, int np, bit ab);
        obs_t w;
        weight_dim = 5'(wd); pixel_count = 10'(pc); num_passes = 4'(np);
        start = 1'b1; abort = ab;
        w = want_at(cyc);
        if (ab) cancel_after(cyc);
        else if (!w.busy) model_run(cyc, wd, pc, np);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_until(int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_idle(string name);
        obs_t g;
        g = observed();
        vectors++;
        if (g !== idle_obs()) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", name, g, idle_obs());
        end
    endtask

    task automatic monitor();
        obs_t  g, w;
        beat_t b;
        forever begin
            @(negedge clk);
            if (nrst) begin
                g = observed();
                w = want_at(cyc);
                vectors++;
                if (g !== w) begin
                    miscompares++;
                    $display("FAIL ctrl cyc=%0d got=%h want=%h", cyc, g, w);
                end
                if (out_valid) begin
                    vectors++;
                    if (beat_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL beat_unexpected cyc=%0d got=1 want=0", cyc);
                    end else begin
                        b = beat_q.pop_front();
                        if (b.c != cyc || b.af !== acc_first || b.pidx !== pass_idx) begin
                            miscompares++;
                            $display("FAIL beat cyc=%0d/%0d af=%0b/%0b pidx=%0d/%0d (got/want)",
                                     cyc, b.c, acc_first, b.af, pass_idx, b.pidx);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, k;
        fork
            monitor();
        join_none
        #2 nrst = 1'b0;
        #10 check_idle("reset");
        @(negedge clk); #1 nrst = 1'b1;
        @(negedge clk);

        // T1 single pass
        n0 = cyc; do_start(3, 5, 1, 0); wait_until(n0 + 17);
        // T2 two passes
        n0 = cyc; do_start(3, 5, 2, 0); wait_until(n0 + 30);
        // T3 illegal configs
        n0 = cyc; do_start(3, 0, 1, 0); wait_until(n0 + 3);
        n0 = cyc; do_start(5, 5, 1, 0); wait_until(n0 + 3);
        // T4 abort in STREAM, then replay
        n0 = cyc; do_start(3, 5, 1, 0);
        wait_until(n0 + 7); abort = 1'b1; cancel_after(cyc);
        @(negedge clk); abort = 1'b0;
        wait_until(n0 + 10); n0 = cyc; do_start(3, 5, 1, 0); wait_until(n0 + 17);
        // abort and start together in IDLE
        n0 = cyc; do_start(3, 5, 1, 1); wait_until(n0 + 4);
        // T5 asynchronous reset mid-DRAIN
        n0 = cyc; do_start(3, 5, 1, 0);
        wait_until(n0 + 11); #1 nrst = 1'b0;
        #1 check_idle("mid_drain_reset");
        cancel_after(n0 + 11);
        @(negedge clk); #2 nrst = 1'b1;
        @(negedge clk);
        // T6 config change and start while busy
        n0 = cyc; do_start(3, 5, 1, 0);
        wait_until(n0 + 6); do_start(3, 9, 1, 0); wait_until(n0 + 17);

        repeat (40) begin
            n0 = cyc;
            do_start($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 3), 0);
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, 25);
                wait_until(n0 + k);
                abort = 1'b1; cancel_after(cyc);
                @(negedge clk); abort = 1'b0;
            end
            wait_until(model_end + 2);
        end

        wait_until(cyc + 3);
        vectors++;
        if (beat_q.size() != 0) begin
            miscompares++;
            $display("FAIL beats_left got=%0d want=0", beat_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
